// File: rtl/lab4_branch_sched_pkg.sv
// Shared types for the branch-predictor port scheduler: FSM state,
// the queued update entry and the PC width.
package lab4_branch_sched_pkg;

  localparam int PC_W = 32;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
  } upd_entry_t;

endpackage

// File: rtl/lab4_branch_bpred_upd_fifo.sv
// In-order FIFO of resolved-branch updates waiting for the predictor port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// No enqueue/dequeue bypass: a newly written entry is visible next cycle.
module lab4_branch_bpred_upd_fifo
  import lab4_branch_sched_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enq_val,
  output logic          enq_rdy,
  input  logic [PC_W:0] enq_data,
  input  logic          deq,
  output logic [PC_W:0] head,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(QDEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  upd_entry_t    mem_q [QDEPTH];
  upd_entry_t    mem_d [QDEPTH];
  logic          do_enq;
  logic          do_deq;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign enq_rdy = !full;
  assign do_enq  = enq_val && !full;
  assign do_deq  = deq && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  // Next storage and pointer values from this cycle's enqueue/dequeue.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_enq) begin
      mem_d[wr_ptr_q[AW-1:0]] = enq_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_deq) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Storage and pointer registers; reset empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/lab4_branch_bpred_port_sched.sv
// Arbitrates the global branch predictor's single PC port between fetch
// lookups (answered combinationally) and queued execute-stage updates.
// Fetch wins by default; an aged or full queue forces an update through,
// and a flush drains every pending update before lookups resume.
// Handshake: lookup completes in a cycle with lookup_val && lookup_rdy;
// an update is accepted in a cycle with upd_val && upd_rdy.
// Optional statistics counters: define LAB4_BRANCH_SCHED_STATS_EN.
module lab4_branch_bpred_port_sched
  import lab4_branch_sched_pkg::*;
#(
  parameter int QDEPTH   = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lookup_val,
  output logic        lookup_rdy,
  input  logic [31:0] lookup_pc,
  output logic        lookup_taken,
  input  logic        upd_val,
  output logic        upd_rdy,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        flush,
  output logic        drain_done,
  output logic [31:0] bp_pc,
  output logic        bp_update_en,
  output logic        bp_update_val,
  input  logic        bp_prediction
`ifdef LAB4_BRANCH_SCHED_STATS_EN
  ,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_lookup_stalls
`endif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  sched_state_e      state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic [PC_W:0] fifo_head;
  upd_entry_t    head_e;
  logic          enq;
  logic          force_upd;
  logic          upd_grant;
  logic          lookup_grant;

  assign head_e = fifo_head;
  assign enq    = upd_val && upd_rdy;

  lab4_branch_bpred_upd_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .enq_val  (upd_val),
    .enq_rdy  (upd_rdy),
    .enq_data ({upd_pc, upd_taken}),
    .deq      (upd_grant),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Port grant: at most one requester per cycle; nothing while in reset.
  always_comb begin
    force_upd    = !fifo_empty && (fifo_full || (wait_cnt_q >= MAX_WAIT_C));
    upd_grant    = 1'b0;
    lookup_grant = 1'b0;
    if (reset) begin
      case (state_q)
        RUN: begin
          if (force_upd) begin
            upd_grant = 1'b1;
          end else if (lookup_val) begin
            lookup_grant = 1'b1;
          end else if (!fifo_empty) begin
            upd_grant = 1'b1;
          end
        end
        DRAIN: begin
          upd_grant = !fifo_empty;
        end
        default: begin
          upd_grant    = 1'b0;
          lookup_grant = 1'b0;
        end
      endcase
    end
  end

  // Predictor-side and fetch-side output muxing driven by the grant.
  always_comb begin
    bp_pc         = '0;
    bp_update_en  = 1'b0;
    bp_update_val = 1'b0;
    lookup_rdy    = 1'b0;
    lookup_taken  = 1'b0;
    if (upd_grant) begin
      bp_pc         = head_e.pc;
      bp_update_en  = 1'b1;
      bp_update_val = head_e.taken;
    end else if (lookup_grant) begin
      bp_pc        = lookup_pc;
      lookup_rdy   = 1'b1;
      lookup_taken = bp_prediction;
    end
  end

  // FSM next state, drain completion pulse and head aging counter.
  always_comb begin
    state_d    = state_q;
    drain_done = 1'b0;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && !enq) begin
          state_d    = RUN;
          drain_done = reset;
        end
      end
      default: state_d = RUN;
    endcase
    if (upd_grant || fifo_empty) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // State and aging counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef LAB4_BRANCH_SCHED_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_updates_q, stat_updates_d;
  logic [31:0] stat_stalls_q, stat_stalls_d;

  assign stat_lookups       = stat_lookups_q;
  assign stat_updates       = stat_updates_q;
  assign stat_lookup_stalls = stat_stalls_q;

  // Event counters, wrapping naturally at 2^32.
  always_comb begin
    stat_lookups_d = stat_lookups_q;
    stat_updates_d = stat_updates_q;
    stat_stalls_d  = stat_stalls_q;
    if (lookup_grant) stat_lookups_d = stat_lookups_q + 32'd1;
    if (upd_grant) stat_updates_d = stat_updates_q + 32'd1;
    if (lookup_val && !lookup_rdy) stat_stalls_d = stat_stalls_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_lookups_q <= '0;
      stat_updates_q <= '0;
      stat_stalls_q  <= '0;
    end else begin
      stat_lookups_q <= stat_lookups_d;
      stat_updates_q <= stat_updates_d;
      stat_stalls_q  <= stat_stalls_d;
    end
  end
`endif

endmodule
